apb_master_arbiter: RTL and testbench

Multi-requester APB master: accepts read/write requests from NREQ local requesters, arbitrates round-robin, and sequences each winner through the APB IDLE → SETUP → ACCESS protocol toward a single APB slave (e.g. the team's APB_module register slave). It honours slave wait states via PREADY, terminates hung transfers with a timeout error, and returns read data and status to the granted requester.

---
 rtl/apb_master_arbiter_if.sv | 37 +++
 rtl/apb_master_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbitrating master and a single APB slave.
// Signal names follow the AMBA APB naming so the slave side can be wired directly.
interface apb_master_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   modport master (
      output PSEL,
      output PENABLE,
      output PWRITE,
      output PADDR,
      output PWDATA,
      input  PRDATA,
      input  PREADY,
      input  PSLVERR
   );

   modport slave (
      input  PSEL,
      input  PENABLE,
      input  PWRITE,
      input  PADDR,
      input  PWDATA,
      output PRDATA,
      output PREADY,
      output PSLVERR
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: arbitrates NREQ local requesters onto one APB slave,
// honours PREADY wait states and forces an error completion on a hung slave.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus idle, arbitrate among req_valid, latch winner
// ST_SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ST_ACCESS | PSEL=1, PENABLE=1 until PREADY or wait-timer expiry
module apb_master_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    req_done,
   output logic [DW-1:0]      req_rdata,
   output logic               req_err,
   apb_master_arbiter_if.master apb
);

   localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit              TMR_EN   = (TIMEOUT > 0);
   localparam logic [TW-1:0]   TMR_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0]   LAST_REQ = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t        state_q, state_nx;
   logic [IW-1:0] ptr_q, ptr_nx;
   logic [IW-1:0] gnt_q, gnt_nx;
   logic [TW-1:0] tmr_q, tmr_nx;
   logic          psel_q, psel_nx;
   logic          penable_q, penable_nx;
   logic          pwrite_q, pwrite_nx;
   logic [AW-1:0] paddr_q, paddr_nx;
   logic [DW-1:0] pwdata_q, pwdata_nx;

   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW:0]   cand;
   logic          tmr_expired;
   logic          xfer_end;

   // Rotating-priority search: first valid requester at or after ptr_q.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int j = 0; j < NREQ; j++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(j);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!win_found && req_valid[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   assign tmr_expired = TMR_EN && (tmr_q == '0);
   assign xfer_end    = (state_q == ST_ACCESS) && (apb.PREADY || tmr_expired);

   always_comb begin
      state_nx  = state_q;
      ptr_nx    = ptr_q;
      gnt_nx    = gnt_q;
      tmr_nx    = tmr_q;
      pwrite_nx = pwrite_q;
      paddr_nx  = paddr_q;
      pwdata_nx = pwdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_nx  = ST_SETUP;
               gnt_nx    = win_idx;
               ptr_nx    = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
               pwrite_nx = req_write[win_idx];
               paddr_nx  = req_addr[win_idx*AW +: AW];
               pwdata_nx = req_wdata[win_idx*DW +: DW];
            end
         end
         ST_SETUP: begin
            state_nx = ST_ACCESS;
            tmr_nx   = TMR_LOAD;
         end
         ST_ACCESS: begin
            if (xfer_end) begin
               state_nx = ST_IDLE;
            end else if (tmr_q != '0) begin
               tmr_nx = tmr_q - 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
      psel_nx    = (state_nx != ST_IDLE);
      penable_nx = (state_nx == ST_ACCESS);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         tmr_q     <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         state_q   <= state_nx;
         ptr_q     <= ptr_nx;
         gnt_q     <= gnt_nx;
         tmr_q     <= tmr_nx;
         psel_q    <= psel_nx;
         penable_q <= penable_nx;
         pwrite_q  <= pwrite_nx;
         paddr_q   <= paddr_nx;
         pwdata_q  <= pwdata_nx;
      end
   end

   // A real PREADY in the expiry cycle wins, so slave status is reported.
   always_comb begin
      req_done  = '0;
      req_rdata = '0;
      req_err   = 1'b0;
      if (xfer_end) begin
         req_done[gnt_q] = 1'b1;
         if (apb.PREADY) begin
            req_rdata = apb.PRDATA;
            req_err   = apb.PSLVERR;
         end else begin
            req_err   = 1'b1;
         end
      end
   end

   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transfer-position model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_apb_master_arbiter;
   localparam int AW = 32, DW = 32, NREQ = 2, TIMEOUT = 4;

   logic               PCLK = 1'b0;
   logic               PRESETn = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_write = '0;
   logic [NREQ*AW-1:0] req_addr  = '0;
   logic [NREQ*DW-1:0] req_wdata = '0;
   logic [NREQ-1:0]    req_done;
   logic [DW-1:0]      req_rdata;
   logic               req_err;

   apb_master_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   apb_master_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .req_rdata (req_rdata),
      .req_err   (req_err),
      .apb       (bus)
   );

   always #5 PCLK = ~PCLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_pos counts cycles into the current transfer (0 = bus free,
   // 1 = setup cycle, k>=2 = access cycle k-1).
   int            m_pos = 0;
   int            m_grant = 0;
   int            m_ptr = 0;
   logic          m_write = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;

   function automatic bit m_done_now();
      return (m_pos >= 2) && ((bus.PREADY === 1'b1) || (TIMEOUT != 0 && (m_pos - 1) == TIMEOUT));
   endfunction

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         m_pos   <= 0;
         m_grant <= 0;
         m_ptr   <= 0;
         m_write <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else if (m_pos == 0) begin : pick
         int w;
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         end
         if (w >= 0) begin
            m_pos   <= 1;
            m_grant <= w;
            m_ptr   <= (w + 1) % NREQ;
            m_write <= req_write[w];
            m_addr  <= req_addr[w*AW +: AW];
            m_wdata <= req_wdata[w*DW +: DW];
         end
      end else if (m_done_now()) begin
         m_pos <= 0;
      end else begin
         m_pos <= m_pos + 1;
      end
   end

   always @(negedge PCLK) begin : compare
      logic [NREQ-1:0] exp_done;
      exp_done = '0;
      if (m_done_now()) exp_done[m_grant] = 1'b1;
      check("PSEL",     bus.PSEL,    m_pos >= 1);
      check("PENABLE",  bus.PENABLE, m_pos >= 2);
      check("PWRITE",   bus.PWRITE,  m_write);
      check("PADDR",    bus.PADDR,   m_addr);
      check("PWDATA",   bus.PWDATA,  m_wdata);
      check("req_done", req_done,    exp_done);
      if (exp_done != '0) begin
         check("req_rdata", req_rdata, bus.PREADY ? bus.PRDATA : '0);
         check("req_err",   req_err,   bus.PREADY ? bus.PSLVERR : 1'b1);
      end
   end

   // Requester/slave behaviour and per-cycle samples
   int            pend [NREQ];
   int            acc_cnt = 0;
   int            slv_wait = 0;
   bit            slv_hang = 1'b0;
   logic [DW-1:0] slv_rdata = '0;
   logic          slv_err = 1'b0;
   int            order_q [$];
   logic [NREQ-1:0] s_done;
   logic          s_psel, s_pen, s_err;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata, s_rdata;

   task automatic tick();
      @(negedge PCLK); #1;
      s_done  = req_done;
      s_psel  = bus.PSEL;
      s_pen   = bus.PENABLE;
      s_addr  = bus.PADDR;
      s_wdata = bus.PWDATA;
      s_rdata = req_rdata;
      s_err   = req_err;
      for (int i = 0; i < NREQ; i++) if (s_done[i]) order_q.push_back(i);
      @(posedge PCLK); #1;
      for (int i = 0; i < NREQ; i++) begin
         if (s_done[i] && pend[i] > 0) pend[i]--;
         req_valid[i] = (pend[i] > 0);
      end
      if (bus.PENABLE) begin
         bus.PREADY = !slv_hang && (acc_cnt >= slv_wait);
         acc_cnt++;
      end else begin
         bus.PREADY = 1'b0;
         acc_cnt = 0;
      end
      bus.PRDATA  = slv_rdata;
      bus.PSLVERR = slv_err;
   endtask

   task automatic request(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int n);
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      pend[i]               = n;
      req_valid[i]          = 1'b1;
   endtask

   task automatic run_until(input int idx, input int budget, input logic [AW-1:0] addr,
                            output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
         if (s_psel) check("paddr_stable", s_addr, addr);
      end while (!s_done[idx] && cycles < budget);
      check("done_within_budget", s_done[idx], 1'b1);
   endtask

   initial begin
      int cyc;
      int guard;
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
      #1 PRESETn = 1'b0;
      repeat (2) tick();
      check("rst_psel",    bus.PSEL, 1'b0);
      check("rst_penable", bus.PENABLE, 1'b0);
      check("rst_paddr",   bus.PADDR, 32'd0);
      check("rst_done",    req_done, 2'b00);
      PRESETn = 1'b1;

      // single zero-wait write
      slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hDEAD;
      request(0, 1'b1, 32'd500, 32'd123, 1);
      tick();
      check("wr_idle_psel", s_psel, 1'b0);
      tick();
      check("wr_setup_psel", s_psel, 1'b1);
      check("wr_setup_pen",  s_pen, 1'b0);
      tick();
      check("wr_acc_pen",   s_pen, 1'b1);
      check("wr_acc_paddr", s_addr, 32'd500);
      check("wr_acc_wdata", s_wdata, 32'd123);
      check("wr_done",      s_done, 2'b01);
      check("wr_err",       s_err, 1'b0);
      tick();
      check("wr_after_psel", s_psel, 1'b0);

      // read on requester 1 with two wait states
      slv_wait = 2; slv_rdata = 32'd123;
      request(1, 1'b0, 32'd500, 32'd0, 1);
      run_until(1, 20, 32'd500, cyc);
      check("rd_cycles", cyc, 5);
      check("rd_done",   s_done, 2'b10);
      check("rd_rdata",  s_rdata, 32'd123);
      check("rd_err",    s_err, 1'b0);

      // slave error on a write
      slv_wait = 0; slv_err = 1'b1;
      request(0, 1'b1, 32'h40, 32'h55, 1);
      run_until(0, 20, 32'h40, cyc);
      check("slverr_cycles", cyc, 3);
      check("slverr_err",    s_err, 1'b1);
      slv_err = 1'b0;

      // timeout on a hung read
      slv_hang = 1'b1; slv_rdata = 32'hBEEF;
      request(1, 1'b0, 32'h80, 32'd0, 1);
      run_until(1, 20, 32'h80, cyc);
      check("to_cycles", cyc, 2 + TIMEOUT);
      check("to_err",    s_err, 1'b1);
      check("to_rdata",  s_rdata, 32'd0);
      tick();
      check("to_psel_drop", s_psel, 1'b0);
      slv_hang = 1'b0;

      // contention from reset: grants alternate 0,1,0,1
      PRESETn = 1'b0;
      repeat (2) tick();
      PRESETn = 1'b1;
      order_q.delete();
      request(0, 1'b1, 32'h100, 32'h11, 2);
      request(1, 1'b1, 32'h200, 32'h22, 2);
      guard = 0;
      while ((pend[0] > 0 || pend[1] > 0) && guard < 40) begin
         tick();
         guard++;
      end
      check("cont_drained", pend[0] + pend[1], 0);
      check("cont_count",   order_q.size(), 4);
      for (int k = 0; k < order_q.size() && k < 4; k++) check("cont_order", order_q[k], k % 2);

      // reset during an ACCESS wait state
      slv_hang = 1'b1;
      request(0, 1'b0, 32'h300, 32'd0, 1);
      guard = 0;
      do begin tick(); guard++; end while (!s_pen && guard < 10);
      check("mid_reached_access", s_pen, 1'b1);
      #2 PRESETn = 1'b0;
      #1;
      check("mid_rst_psel", bus.PSEL, 1'b0);
      check("mid_rst_pen",  bus.PENABLE, 1'b0);
      check("mid_rst_done", req_done, 2'b00);
      repeat (2) tick();
      slv_hang = 1'b0; slv_rdata = 32'h777;
      PRESETn = 1'b1;
      run_until(0, 20, 32'h300, cyc);
      check("mid_cycles", cyc, 3);
      check("mid_rdata",  s_rdata, 32'h777);
      check("mid_err",    s_err, 1'b0);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, time %0t limit 200000", $time);
      $fatal(1, "watchdog");
   end
endmodule
